// File: rtl/gtp_rx_deframer.sv
// GTP receive deframer: qualifies link lock on IDLE fill, extracts SOF/EOF frames
// into the RX FIFO and checks the XOR checksum. Define RX_ERRCNT_EN to add err_cnt.
module gtp_rx_deframer #(
    parameter int LOCK_IDLES = 16,
    parameter int MAX_WORDS  = 256
`ifdef RX_ERRCNT_EN
    ,
    parameter int ERRCNT_W   = 16
`endif
) (
    input  logic        gtp_clk,
    input  logic        reset,
    input  logic        rxinit_done,
    input  logic [15:0] rxdata,
    input  logic [1:0]  rxcharisk,
    input  logic        fifo_full,
    output logic [15:0] fifo_din,
    output logic        fifo_we,
    output logic        link_up,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        overflow
`ifdef RX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    localparam int IDLE_W = $clog2(LOCK_IDLES + 1);
    localparam int WCNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        ST_WAIT_INIT,
        ST_SYNC,
        ST_LINKED,
        ST_FRAME
    } state_t;

    typedef enum logic [2:0] {
        W_PAYLOAD,
        W_IDLE,
        W_SOF,
        W_EOF,
        W_ILLEGAL
    } word_t;

    state_t              state, state_nxt;
    word_t               wclass;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
    logic [WCNT_W-1:0]   word_cnt, word_cnt_nxt;
    logic [7:0]          checksum, checksum_nxt;
    logic                bad, bad_nxt;
    logic [15:0]         din_nxt;
    logic                we_nxt, link_nxt, done_nxt, ok_nxt, ovf_nxt;
    logic                drop;

    always_comb begin
        wclass = W_ILLEGAL;
        if (rxcharisk == 2'b00)
            wclass = W_PAYLOAD;
        else if (rxcharisk == 2'b01) begin
            if (rxdata == 16'h50BC)
                wclass = W_IDLE;
            else if (rxdata == 16'h00FB)
                wclass = W_SOF;
            else if (rxdata[7:0] == 8'hFD)
                wclass = W_EOF;
        end
    end

    // All outputs are registered, so this block computes every register's next value.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = '0;
        word_cnt_nxt = word_cnt;
        checksum_nxt = checksum;
        bad_nxt      = bad;
        din_nxt      = fifo_din;
        we_nxt       = 1'b0;
        link_nxt     = link_up;
        done_nxt     = 1'b0;
        ok_nxt       = 1'b0;
        ovf_nxt      = overflow;
        drop         = 1'b0;

        if (!rxinit_done) begin
            state_nxt = ST_WAIT_INIT;
            link_nxt  = 1'b0;
        end else begin
            case (state)
                ST_WAIT_INIT: state_nxt = ST_SYNC;
                ST_SYNC: begin
                    if (wclass == W_IDLE) begin
                        if (idle_cnt == IDLE_W'(LOCK_IDLES - 1)) begin
                            state_nxt = ST_LINKED;
                            link_nxt  = 1'b1;
                        end else begin
                            idle_cnt_nxt = idle_cnt + 1'b1;
                        end
                    end
                end
                ST_LINKED: begin
                    if (wclass == W_SOF) begin
                        state_nxt    = ST_FRAME;
                        word_cnt_nxt = '0;
                        checksum_nxt = '0;
                        bad_nxt      = 1'b0;
                    end else if (wclass == W_ILLEGAL) begin
                        state_nxt = ST_SYNC;
                        link_nxt  = 1'b0;
                        drop      = 1'b1;
                    end
                end
                ST_FRAME: begin
                    case (wclass)
                        W_PAYLOAD: begin
                            if (word_cnt == WCNT_W'(MAX_WORDS)) begin
                                done_nxt  = 1'b1;
                                state_nxt = ST_SYNC;
                                drop      = 1'b1;
                            end else begin
                                din_nxt      = rxdata;
                                we_nxt       = ~fifo_full;
                                ovf_nxt      = overflow | fifo_full;
                                bad_nxt      = bad | fifo_full;
                                checksum_nxt = checksum ^ rxdata[15:8] ^ rxdata[7:0];
                                word_cnt_nxt = word_cnt + 1'b1;
                            end
                        end
                        W_EOF: begin
                            done_nxt  = 1'b1;
                            ok_nxt    = (rxdata[15:8] == checksum) && !bad && (word_cnt != '0);
                            state_nxt = ST_LINKED;
                        end
                        // A new SOF aborts the open frame and starts the next one in place.
                        W_SOF: begin
                            done_nxt     = 1'b1;
                            word_cnt_nxt = '0;
                            checksum_nxt = '0;
                            bad_nxt      = 1'b0;
                        end
                        W_ILLEGAL: begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_SYNC;
                            link_nxt  = 1'b0;
                            drop      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_nxt = ST_WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge gtp_clk) begin
        if (!reset) begin
            state      <= ST_WAIT_INIT;
            idle_cnt   <= '0;
            word_cnt   <= '0;
            checksum   <= '0;
            bad        <= 1'b0;
            fifo_din   <= '0;
            fifo_we    <= 1'b0;
            link_up    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            idle_cnt   <= idle_cnt_nxt;
            word_cnt   <= word_cnt_nxt;
            checksum   <= checksum_nxt;
            bad        <= bad_nxt;
            fifo_din   <= din_nxt;
            fifo_we    <= we_nxt;
            link_up    <= link_nxt;
            frame_done <= done_nxt;
            frame_ok   <= ok_nxt;
            overflow   <= ovf_nxt;
        end
    end

`ifdef RX_ERRCNT_EN
    // A bad frame_done and a drop to SYNC on the same word count as one error.
    logic err_evt;
    assign err_evt = (done_nxt && !ok_nxt) || drop;

    always_ff @(posedge gtp_clk) begin
        if (!reset)
            err_cnt <= '0;
        else if (err_evt && !(&err_cnt))
            err_cnt <= err_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// Testbench for gtp_rx_deframer: directed and randomized frames checked against a
// frame-level reference model (expected writes, checksum, lock and error events).
module tb_gtp_rx_deframer;

    localparam int LOCKN = 16;
    localparam int MAXW  = 4;
    localparam logic [15:0] IDLE_W = 16'h50BC;
    localparam logic [15:0] SOF_W  = 16'h00FB;

    logic        gtp_clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxinit_done = 1'b0;
    logic [15:0] rxdata = 16'h0000;
    logic [1:0]  rxcharisk = 2'b00;
    logic        fifo_full = 1'b0;
    logic [15:0] fifo_din;
    logic        fifo_we;
    logic        link_up;
    logic        frame_done;
    logic        frame_ok;
    logic        overflow;
`ifdef RX_ERRCNT_EN
    logic [15:0] err_cnt;
    int          exp_err = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_link = 1'b0;
    logic exp_ovf  = 1'b0;

    gtp_rx_deframer #(
        .LOCK_IDLES(LOCKN),
        .MAX_WORDS (MAXW)
    ) dut (
        .gtp_clk    (gtp_clk),
        .reset      (reset),
        .rxinit_done(rxinit_done),
        .rxdata     (rxdata),
        .rxcharisk  (rxcharisk),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_we    (fifo_we),
        .link_up    (link_up),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .overflow   (overflow)
`ifdef RX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 gtp_clk = ~gtp_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic full);
        @(negedge gtp_clk);
        rxdata    = d;
        rxcharisk = k;
        fifo_full = full;
        @(posedge gtp_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic note_err();
`ifdef RX_ERRCNT_EN
        exp_err++;
`endif
    endtask

    task automatic expect_outs(input string tag, input logic we, input logic [15:0] din,
                               input logic done, input logic ok);
        chk({tag, ".fifo_we"}, 16'(fifo_we), 16'(we));
        if (we)
            chk({tag, ".fifo_din"}, fifo_din, din);
        chk({tag, ".frame_done"}, 16'(frame_done), 16'(done));
        if (done)
            chk({tag, ".frame_ok"}, 16'(frame_ok), 16'(ok));
        chk({tag, ".link_up"}, 16'(link_up), 16'(exp_link));
        chk({tag, ".overflow"}, 16'(overflow), 16'(exp_ovf));
`ifdef RX_ERRCNT_EN
        chk({tag, ".err_cnt"}, err_cnt, 16'(exp_err));
`endif
    endtask

    task automatic quiet(input string tag, input logic [15:0] d, input logic [1:0] k);
        drive(d, k, 1'b0);
        expect_outs(tag, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge gtp_clk);
        reset = 1'b0;
        @(posedge gtp_clk);
        #1;
        exp_link = 1'b0;
        exp_ovf  = 1'b0;
`ifdef RX_ERRCNT_EN
        exp_err  = 0;
`endif
        chk({tag, ".fifo_din"}, fifo_din, 16'h0000);
        chk({tag, ".frame_ok"}, 16'(frame_ok), 16'h0000);
        expect_outs(tag, 1'b0, 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // n IDLE words, counted from a fresh (non-IDLE) predecessor
    task automatic idles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            drive(IDLE_W, 2'b01, 1'b0);
            if (i >= LOCKN - 1)
                exp_link = 1'b1;
            expect_outs(tag, 1'b0, 16'h0000, 1'b0, 1'b0);
        end
    endtask

    // Sends one SOF..EOF frame; returns early (state SYNC) if it exceeds MAXW words.
    task automatic send_frame(input string tag, input logic [15:0] words[$],
                              input logic [7:0] fullm, input logic [7:0] chkv, input bit fill);
        logic [7:0] x;
        bit bad;
        int n;
        logic ok;
        x = 8'h00;
        bad = 1'b0;
        n = 0;
        quiet({tag, ".sof"}, SOF_W, 2'b01);
        for (int i = 0; i < words.size(); i++) begin
            if (fill && $urandom_range(0, 2) == 0) begin
                drive(IDLE_W, 2'b01, 1'($urandom_range(0, 1)));
                expect_outs({tag, ".fill"}, 1'b0, 16'h0000, 1'b0, 1'b0);
            end
            drive(words[i], 2'b00, fullm[i]);
            if (n == MAXW) begin
                note_err();
                expect_outs({tag, ".overlen"}, 1'b0, 16'h0000, 1'b1, 1'b0);
                return;
            end
            if (fullm[i]) begin
                bad = 1'b1;
                exp_ovf = 1'b1;
            end
            x = x ^ words[i][15:8] ^ words[i][7:0];
            n++;
            expect_outs({tag, ".pay"}, !fullm[i], words[i], 1'b0, 1'b0);
        end
        drive({chkv, 8'hFD}, 2'b01, 1'b0);
        ok = (chkv == x) && !bad && (n != 0);
        if (!ok)
            note_err();
        expect_outs({tag, ".eof"}, 1'b0, 16'h0000, 1'b1, ok);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [7:0]  fm;
        logic [7:0]  cx;
        int          nw;

        do_reset("reset");

        rxinit_done = 1'b1;
        quiet("init", 16'h0000, 2'b00);
        idles("lock15", LOCKN - 1);
        quiet("lock15.payload", 16'hA5A5, 2'b00);
        idles("lock16", LOCKN);
        chk("lock16.link", 16'(link_up), 16'h0001);

        quiet("linked.payload_ignored", 16'h1111, 2'b00);
        quiet("linked.eof_ignored", 16'h00FD, 2'b01);

        q = {16'h1234, 16'h00FF};
        send_frame("good", q, 8'h00, 8'hD9, 1'b0);
        send_frame("badchk", q, 8'h00, 8'h00, 1'b0);
        send_frame("backpressure", q, 8'h02, 8'hD9, 1'b0);
        q.delete();
        send_frame("empty", q, 8'h00, 8'h00, 1'b0);

        // abort: SOF inside a frame closes it bad and opens a new one
        quiet("abort.sof", SOF_W, 2'b01);
        drive(16'hBEEF, 2'b00, 1'b0);
        expect_outs("abort.w1", 1'b1, 16'hBEEF, 1'b0, 1'b0);
        drive(SOF_W, 2'b01, 1'b0);
        note_err();
        expect_outs("abort.sof2", 1'b0, 16'h0000, 1'b1, 1'b0);
        drive(16'h0F0E, 2'b00, 1'b0);
        expect_outs("abort.w2", 1'b1, 16'h0F0E, 1'b0, 1'b0);
        drive(16'h01FD, 2'b01, 1'b0);
        expect_outs("abort.eof", 1'b0, 16'h0000, 1'b1, 1'b1);

        q = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        send_frame("overlen", q, 8'h00, 8'h00, 1'b0);
        quiet("sync.sof", SOF_W, 2'b01);
        quiet("sync.payload", 16'h7777, 2'b00);
        idles("relock", LOCKN);
        drive(16'h1234, 2'b11, 1'b0);
        exp_link = 1'b0;
        note_err();
        expect_outs("linked.illegal", 1'b0, 16'h0000, 1'b0, 1'b0);
        idles("relock2", LOCKN);

        quiet("frill.sof", SOF_W, 2'b01);
        drive(16'h4242, 2'b00, 1'b0);
        expect_outs("frill.w", 1'b1, 16'h4242, 1'b0, 1'b0);
        drive(16'h00FB, 2'b10, 1'b0);
        exp_link = 1'b0;
        note_err();
        expect_outs("frill.illegal", 1'b0, 16'h0000, 1'b1, 1'b0);
        idles("relock3", LOCKN);

        // rxinit_done dropping discards the frame silently
        quiet("initdrop.sof", SOF_W, 2'b01);
        drive(16'h5555, 2'b00, 1'b0);
        expect_outs("initdrop.w", 1'b1, 16'h5555, 1'b0, 1'b0);
        rxinit_done = 1'b0;
        drive(16'h00AA, 2'b01, 1'b0);
        exp_link = 1'b0;
        expect_outs("initdrop.eof", 1'b0, 16'h0000, 1'b0, 1'b0);
        rxinit_done = 1'b1;
        quiet("initdrop.reinit", 16'h0000, 2'b00);
        idles("relock4", LOCKN);

        for (int it = 0; it < 40; it++) begin
            q.delete();
            nw = $urandom_range(0, MAXW);
            fm = 8'h00;
            cx = 8'h00;
            for (int i = 0; i < nw; i++) begin
                q.push_back(16'($urandom));
                cx = cx ^ q[i][15:8] ^ q[i][7:0];
                if ($urandom_range(0, 9) == 0)
                    fm[i] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0)
                cx = cx ^ 8'($urandom_range(1, 255));
            send_frame("rand", q, fm, cx, 1'b1);
        end

        // reset in the middle of a frame: no frame_done, full relock required
        quiet("rstmid.sof", SOF_W, 2'b01);
        drive(16'hCAFE, 2'b00, 1'b0);
        expect_outs("rstmid.w1", 1'b1, 16'hCAFE, 1'b0, 1'b0);
        drive(16'hF00D, 2'b00, 1'b0);
        expect_outs("rstmid.w2", 1'b1, 16'hF00D, 1'b0, 1'b0);
        do_reset("rstmid");
        quiet("rstmid.init", 16'h0000, 2'b00);
        idles("rstmid.lock", LOCKN);
        q = {16'h1234, 16'h00FF};
        send_frame("postreset", q, 8'h00, 8'hD9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
